// File: rtl/img_pkg.sv
// Shared types for the image pair unpacker.
//   PIX_W / PAIR_W : width of one RGB888 pixel and of one buffered pixel pair.
//   pair_t         : pair layout as it sits in the FIFO, even pixel in the upper half.
//   state_e        : unpack FSM states.
//   even_pix/odd_pix : extract {R,G,B} of either pixel from a pair.
package img_pkg;

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned PAIR_W = 48;

    typedef struct packed {
        logic [7:0] r0;
        logic [7:0] g0;
        logic [7:0] b0;
        logic [7:0] r1;
        logic [7:0] g1;
        logic [7:0] b1;
    } pair_t;

    typedef enum logic {
        ST_EVEN = 1'b0,
        ST_ODD  = 1'b1
    } state_e;

    function automatic logic [PIX_W-1:0] even_pix(input pair_t p);
        return {p.r0, p.g0, p.b0};
    endfunction

    function automatic logic [PIX_W-1:0] odd_pix(input pair_t p);
        return {p.r1, p.g1, p.b1};
    endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous show-ahead FIFO holding pixel pairs.
//   clk_i, rst_ni : clock, asynchronous active-low reset (pointers only).
//   wr_en_i/wr_data_i : write request; ignored while full.
//   rd_en_i       : pop the head entry; ignored while empty.
//   head_o        : current head entry, valid whenever empty_o is low.
//   full_o, empty_o, level_o : occupancy status.
module pair_fifo #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned DATA_W = 48
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_W-1:0]        head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        do_wr, do_rd;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_wr = wr_en_i && !full_o;
    assign do_rd = rd_en_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/image_pair_unpacker.sv
// Converts a two-pixel-per-cycle RGB888 stream into a one-pixel-per-cycle
// valid/ready stream with end-of-line / end-of-frame markers.
//   HCLK, HRESETn       : clock, asynchronous active-low reset.
//   HSYNC, DATA_*0/1    : incoming pixel pair, no backpressure to the source.
//   pix_data/valid/ready: output pixel handshake, {R,G,B}.
//   pix_eol, pix_eof    : position markers travelling with pix_data.
//   frame_done          : one-cycle pulse after the eof pixel transfers.
//   overflow            : sticky, a pair arrived while the FIFO was full.
//   fifo_level          : FIFO occupancy in pairs.
module image_pair_unpacker
    import img_pkg::*;
#(
    parameter int unsigned WIDTH      = 100,
    parameter int unsigned HEIGHT     = 100,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          HSYNC,
    input  logic [7:0]                    DATA_R0,
    input  logic [7:0]                    DATA_G0,
    input  logic [7:0]                    DATA_B0,
    input  logic [7:0]                    DATA_R1,
    input  logic [7:0]                    DATA_G1,
    input  logic [7:0]                    DATA_B1,
    output logic [PIX_W-1:0]              pix_data,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic                          pix_eol,
    output logic                          pix_eof,
    output logic                          frame_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

    pair_t  wr_pair, head;
    logic   fifo_full, fifo_empty;
    logic   push, pop, load, transfer, can_load;
    logic [PIX_W-1:0] load_pix;

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic             valid_q, valid_d;
    logic [PIX_W-1:0] data_q, data_d;
    logic             eol_q, eol_d;
    logic             eof_q, eof_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;

    assign wr_pair = '{r0: DATA_R0, g0: DATA_G0, b0: DATA_B0,
                       r1: DATA_R1, g1: DATA_G1, b1: DATA_B1};

    // Fullness is taken before any same-cycle pop, so a pair arriving while
    // full is always dropped.
    assign push = HSYNC && !fifo_full;

    pair_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (PAIR_W)
    ) u_fifo (
        .clk_i     (HCLK),
        .rst_ni    (HRESETn),
        .wr_en_i   (push),
        .wr_data_i (wr_pair),
        .rd_en_i   (pop),
        .head_o    (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

    assign transfer = valid_q && pix_ready;
    // Output register may take a new pixel if idle or draining this edge.
    assign can_load = !valid_q || pix_ready;

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        valid_d      = valid_q;
        data_d       = data_q;
        eol_d        = eol_q;
        eof_d        = eof_q;
        pop          = 1'b0;
        load         = 1'b0;
        load_pix     = '0;
        frame_done_d = transfer && eof_q;
        overflow_d   = overflow_q || (HSYNC && fifo_full);

        unique case (state_q)
            ST_EVEN: begin
                if (can_load && !fifo_empty) begin
                    load     = 1'b1;
                    load_pix = even_pix(head);
                    state_d  = ST_ODD;
                end
            end
            ST_ODD: begin
                // The even pixel is in the register; the head entry is
                // retired as soon as its odd pixel moves out of the FIFO.
                if (transfer) begin
                    load     = 1'b1;
                    load_pix = odd_pix(head);
                    pop      = 1'b1;
                    state_d  = ST_EVEN;
                end
            end
            default: state_d = ST_EVEN;
        endcase

        if (load) begin
            valid_d = 1'b1;
            data_d  = load_pix;
            eol_d   = (col_q == ColLast);
            eof_d   = (col_q == ColLast) && (row_q == RowLast);
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (transfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= ST_EVEN;
            col_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            eol_q        <= eol_d;
            eof_q        <= eof_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pix_valid  = valid_q;
    assign pix_data   = data_q;
    assign pix_eol    = eol_q;
    assign pix_eof    = eof_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_image_pair_unpacker.sv
// Directed bench for image_pair_unpacker using a small 4x2 image and a
// 4-entry FIFO so markers, wrap-around and overflow are reachable quickly.
module tb_image_pair_unpacker;

    localparam int unsigned W = 4;
    localparam int unsigned H = 2;
    localparam int unsigned D = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSYNC = 1'b0;
    logic [7:0]  DATA_R0 = '0, DATA_G0 = '0, DATA_B0 = '0;
    logic [7:0]  DATA_R1 = '0, DATA_G1 = '0, DATA_B1 = '0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_eol, pix_eof, frame_done, overflow;
    logic [2:0]  fifo_level;

    int vectors = 0;
    int miscompares = 0;
    int push_seq = 0;
    int exp_seq = 0;
    int pos = 0;

    always #5 HCLK = ~HCLK;

    image_pair_unpacker #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .HSYNC      (HSYNC),
        .DATA_R0    (DATA_R0),
        .DATA_G0    (DATA_G0),
        .DATA_B0    (DATA_B0),
        .DATA_R1    (DATA_R1),
        .DATA_G1    (DATA_G1),
        .DATA_B1    (DATA_B1),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .frame_done (frame_done),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    function automatic logic [23:0] pix_val(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {b ^ 8'hC0, 8'h5A, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_pair(input logic [23:0] e, input logic [23:0] o);
        HSYNC = 1'b1;
        {DATA_R0, DATA_G0, DATA_B0} = e;
        {DATA_R1, DATA_G1, DATA_B1} = o;
    endtask

    task automatic push_next();
        drive_pair(pix_val(push_seq), pix_val(push_seq + 1));
        push_seq += 2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_data"},  32'(pix_data),  32'd0);
        check({tag, "_eol"},   32'(pix_eol),   32'd0);
        check({tag, "_eof"},   32'(pix_eof),   32'd0);
        check({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Push n_push pairs back-to-back while consuming, checking every
    // transferred pixel against the expected sequence and raster position.
    task automatic stream(input int n_push, input int cycles, input int exp_pix,
                          input int exp_fd);
        int got;
        int fd;
        got = 0;
        fd = 0;
        for (int c = 0; c < cycles; c++) begin
            if (c < n_push) push_next();
            else HSYNC = 1'b0;
            if (frame_done) fd++;
            if (pix_valid && pix_ready) begin
                check("stream_data", 32'(pix_data), 32'(pix_val(exp_seq)));
                check("stream_eol", 32'(pix_eol), 32'((pos % W) == W - 1));
                check("stream_eof", 32'(pix_eof), 32'(pos == W * H - 1));
                exp_seq++;
                pos = (pos + 1) % (W * H);
                got++;
            end
            tick();
        end
        HSYNC = 1'b0;
        check("stream_count", 32'(got), 32'(exp_pix));
        check("frame_done_count", 32'(fd), 32'(exp_fd));
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        check_all_zero("reset");
        HRESETn = 1'b1;
        tick();

        // Single pair with consumer ready
        pix_ready = 1'b1;
        drive_pair(24'h112233, 24'h445566);
        tick();
        HSYNC = 1'b0;
        check("single_level_k", 32'(fifo_level), 32'd1);
        check("single_valid_k", 32'(pix_valid), 32'd0);
        tick();
        check("single_valid_k1", 32'(pix_valid), 32'd1);
        check("single_data_k1", 32'(pix_data), 32'h112233);
        check("single_level_k1", 32'(fifo_level), 32'd1);
        tick();
        check("single_valid_k2", 32'(pix_valid), 32'd1);
        check("single_data_k2", 32'(pix_data), 32'h445566);
        check("single_level_k2", 32'(fifo_level), 32'd0);
        check("single_eol_k2", 32'(pix_eol), 32'd0);
        tick();
        check("single_idle", 32'(pix_valid), 32'd0);

        // Backpressure holds the even pixel
        pix_ready = 1'b0;
        drive_pair(24'hAABBCC, 24'hDDEEFF);
        tick();
        HSYNC = 1'b0;
        check("bp_level", 32'(fifo_level), 32'd1);
        tick();
        check("bp_valid", 32'(pix_valid), 32'd1);
        check("bp_data", 32'(pix_data), 32'hAABBCC);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(pix_valid), 32'd1);
            check("bp_hold_data", 32'(pix_data), 32'hAABBCC);
        end
        pix_ready = 1'b1;
        tick();
        check("bp_odd_valid", 32'(pix_valid), 32'd1);
        check("bp_odd_data", 32'(pix_data), 32'hDDEEFF);
        check("bp_odd_eol", 32'(pix_eol), 32'd1);
        check("bp_odd_eof", 32'(pix_eof), 32'd0);
        check("bp_odd_level", 32'(fifo_level), 32'd0);
        tick();
        check("bp_idle", 32'(pix_valid), 32'd0);
        pos = 4;

        // Overflow: fill with consumer stalled, fifth pair is dropped
        pix_ready = 1'b0;
        exp_seq = push_seq;
        for (int i = 0; i < 4; i++) begin
            push_next();
            tick();
            check("ovf_fill_level", 32'(fifo_level), 32'(i + 1));
            check("ovf_fill_flag", 32'(overflow), 32'd0);
        end
        drive_pair(24'hDEAD00, 24'hBEEF00);
        tick();
        HSYNC = 1'b0;
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head_data", 32'(pix_data), 32'(pix_val(exp_seq)));
        pix_ready = 1'b1;
        stream(0, 14, 8, 1);
        check("ovf_drained_level", 32'(fifo_level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset mid-stream
        pix_ready = 1'b0;
        push_next();
        tick();
        HSYNC = 1'b0;
        tick();
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        #1 HRESETn = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        HRESETn = 1'b1;
        pos = 0;
        exp_seq = push_seq;
        pix_ready = 1'b1;

        // Two full frames after reset
        stream(4, 16, 8, 1);
        check("frame1_ovf", 32'(overflow), 32'd0);
        stream(4, 16, 8, 1);
        check("frame2_level", 32'(fifo_level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
